// File: rtl/div_seq_radix2.sv
// Restoring radix-2 divider returning {remainder, quotient}; optional DIV_EARLY_OUT_EN skips iterations when |dividend| < |divisor|.
// Latency: result after 32 iterations past the start edge, one edge for divide-by-zero (zero with early-out).
// Backpressure: result and ready_o are held in END while start_i stays high; start_i low returns to FREE.
module div_seq_radix2 #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o,
    output logic [1:0]            state
);

    typedef enum logic [1:0] {
        FREE   = 2'b00,
        BYZERO = 2'b01,
        ON     = 2'b10,
        END    = 2'b11
    } state_t;

    state_t               cur;
    logic [2*DATA_W:0]    part_q;
    logic [DATA_W-1:0]    divisor_q;
    logic                 neg_quot_q;
    logic                 neg_rem_q;
    logic [CNT_W-1:0]     cnt_q;

    logic [DATA_W-1:0]    abs1;
    logic [DATA_W-1:0]    abs2;
    logic [2*DATA_W:0]    shifted;
    logic [DATA_W:0]      diff;
    logic [2*DATA_W:0]    part_nxt;
    logic [DATA_W-1:0]    quot;
    logic [DATA_W-1:0]    rem;
    logic [DATA_W-1:0]    quot_fix;
    logic [DATA_W-1:0]    rem_fix;

    assign state = cur;

    assign abs1 = (signed_div_i && opdata1_i[DATA_W-1]) ? (~opdata1_i + 1'b1) : opdata1_i;
    assign abs2 = (signed_div_i && opdata2_i[DATA_W-1]) ? (~opdata2_i + 1'b1) : opdata2_i;

    // Upper DATA_W+1 bits hold the partial remainder, lower bits shift out dividend and in quotient.
    assign shifted  = {part_q[2*DATA_W-1:0], 1'b0};
    assign diff     = shifted[2*DATA_W:DATA_W] - {1'b0, divisor_q};
    assign part_nxt = diff[DATA_W] ? shifted : {diff, shifted[DATA_W-1:1], 1'b1};
    assign quot     = part_nxt[DATA_W-1:0];
    assign rem      = part_nxt[2*DATA_W-1:DATA_W];
    assign quot_fix = neg_quot_q ? (~quot + 1'b1) : quot;
    assign rem_fix  = neg_rem_q  ? (~rem + 1'b1)  : rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            cur        <= FREE;
            part_q     <= '0;
            divisor_q  <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            cnt_q      <= '0;
            result_o   <= '0;
            ready_o    <= 1'b0;
        end else begin
            case (cur)
                FREE: begin
                    ready_o  <= 1'b0;
                    result_o <= '0;
                    if (start_i && !annul_i) begin
                        if (opdata2_i == '0) begin
                            cur <= BYZERO;
                        end else begin
`ifdef DIV_EARLY_OUT_EN
                            if (abs1 < abs2) begin
                                result_o <= {opdata1_i, {DATA_W{1'b0}}};
                                ready_o  <= 1'b1;
                                cur      <= END;
                            end else
`endif
                            begin
                                part_q     <= {{(DATA_W+1){1'b0}}, abs1};
                                divisor_q  <= abs2;
                                neg_quot_q <= signed_div_i && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                                neg_rem_q  <= signed_div_i && opdata1_i[DATA_W-1];
                                cnt_q      <= '0;
                                cur        <= ON;
                            end
                        end
                    end
                end
                BYZERO: begin
                    if (annul_i) begin
                        cur <= FREE;
                    end else begin
                        result_o <= '0;
                        ready_o  <= 1'b1;
                        cur      <= END;
                    end
                end
                ON: begin
                    if (annul_i) begin
                        result_o <= '0;
                        ready_o  <= 1'b0;
                        cur      <= FREE;
                    end else begin
                        part_q <= part_nxt;
                        cnt_q  <= cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(DATA_W - 1)) begin
                            result_o <= {rem_fix, quot_fix};
                            ready_o  <= 1'b1;
                            cur      <= END;
                        end
                    end
                end
                default: begin
                    if (!start_i) begin
                        result_o <= '0;
                        ready_o  <= 1'b0;
                        cur      <= FREE;
                    end
                end
            endcase
        end
    end

endmodule
